// File: rtl/mac_seq.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mac_seq : feeds signed operand pairs to a pipelined MAC and captures each
//           dot-product result behind a valid/ready handshake.
// Revision: 1.0
// -----------------------------------------------------------------------------
module mac_seq #(
  parameter int N_LEN = 16,
  parameter int Q_LEN = 8,
  parameter int LAT   = 3,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_LEN-1:0] in_a,
  input  logic [N_LEN-1:0] in_b,
  input  logic             in_last,
  output logic             mac_ce,
  output logic             mac_sload,
  output logic [N_LEN-1:0] mac_a,
  output logic [N_LEN-1:0] mac_b,
  input  logic             mac_rvalid,
  input  logic [N_LEN-1:0] mac_res,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N_LEN-1:0] res_data,
  output logic             res_err,
  output logic [CW-1:0]    res_cnt
);

  if (LAT < 1 || LAT > 15 || Q_LEN > N_LEN) begin : g_param_check
    $error("mac_seq: LAT must be 1..15 and Q_LEN must not exceed N_LEN");
  end

  localparam logic [3:0] LAT_C = 4'(LAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    FLUSH = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       flush_q, flush_d;
  logic             mac_ce_q, mac_ce_d;
  logic             mac_sload_q, mac_sload_d;
  logic [N_LEN-1:0] mac_a_q, mac_a_d;
  logic [N_LEN-1:0] mac_b_q, mac_b_d;
  logic             res_valid_q, res_valid_d;
  logic [N_LEN-1:0] res_data_q, res_data_d;
  logic             res_err_q, res_err_d;
  logic [CW-1:0]    res_cnt_q, res_cnt_d;
  logic             accept;

  assign in_ready = (state_q == IDLE) || (state_q == ACC);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flush_d     = flush_q;
    mac_ce_d    = 1'b0;
    mac_sload_d = 1'b0;
    mac_a_d     = mac_a_q;
    mac_b_d     = mac_b_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    res_cnt_d   = res_cnt_q;

    case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          mac_ce_d = 1'b1;
          mac_a_d  = in_a;
          mac_b_d  = in_b;
          if (state_q == IDLE) begin
            mac_sload_d = 1'b1;
            cnt_d       = CW'(1);
          end else if (cnt_q != {CW{1'b1}}) begin
            cnt_d = cnt_q + CW'(1);
          end
          if (in_last) begin
            state_d = FLUSH;
            flush_d = LAT_C;
          end else begin
            state_d = ACC;
          end
        end
      end
      FLUSH: begin
        // Zero operands push the last real product through the MAC pipeline.
        if (flush_q != 4'd0) begin
          mac_ce_d = 1'b1;
          mac_a_d  = '0;
          mac_b_d  = '0;
          flush_d  = flush_q - 4'd1;
        end else begin
          res_valid_d = 1'b1;
          res_data_d  = mac_res;
          res_err_d   = ~mac_rvalid;
          res_cnt_d   = cnt_q;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      flush_q     <= '0;
      mac_ce_q    <= 1'b0;
      mac_sload_q <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      res_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flush_q     <= flush_d;
      mac_ce_q    <= mac_ce_d;
      mac_sload_q <= mac_sload_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      res_cnt_q   <= res_cnt_d;
    end
  end

  assign mac_ce    = mac_ce_q;
  assign mac_sload = mac_sload_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign res_cnt   = res_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_seq.sv
`default_nettype none
// tb_mac_seq : two mac_seq instances (CW=8 and CW=2) in lockstep, each driving a
//              behavioural Q8.8 MAC; results checked against exact dot-product sums.
module tb_mac_seq;

  localparam int LAT  = 3;
  localparam int NREC = 8192;

  logic clk = 1'b0;
  logic arst_n;
  logic in_valid, in_last, res_ready;
  logic [15:0] in_a, in_b;
  bit force_err;

  logic [1:0]  in_ready_v, mac_ce_v, mac_sload_v, mac_rvalid_v, res_valid_v, res_err_v;
  logic [15:0] mac_a_v [2];
  logic [15:0] mac_b_v [2];
  logic [15:0] mac_res_v [2];
  logic [15:0] res_data_v [2];
  logic [7:0]  res_cnt0;
  logic [1:0]  res_cnt1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mac_seq #(.N_LEN(16), .Q_LEN(8), .LAT(LAT), .CW(8)) u_dut0 (
    .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mac_ce(mac_ce_v[0]), .mac_sload(mac_sload_v[0]), .mac_a(mac_a_v[0]), .mac_b(mac_b_v[0]),
    .mac_rvalid(mac_rvalid_v[0]), .mac_res(mac_res_v[0]),
    .res_valid(res_valid_v[0]), .res_ready(res_ready), .res_data(res_data_v[0]),
    .res_err(res_err_v[0]), .res_cnt(res_cnt0)
  );

  mac_seq #(.N_LEN(16), .Q_LEN(8), .LAT(LAT), .CW(2)) u_dut1 (
    .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mac_ce(mac_ce_v[1]), .mac_sload(mac_sload_v[1]), .mac_a(mac_a_v[1]), .mac_b(mac_b_v[1]),
    .mac_rvalid(mac_rvalid_v[1]), .mac_res(mac_res_v[1]),
    .res_valid(res_valid_v[1]), .res_ready(res_ready), .res_data(res_data_v[1]),
    .res_err(res_err_v[1]), .res_cnt(res_cnt1)
  );

  // Behavioural MAC: accumulator followed by LAT-1 ce-qualified delay stages.
  longint pipe [2][LAT];
  longint rnd [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mac_ce_v[k]) begin
        for (int j = LAT - 1; j > 0; j--) pipe[k][j] <= pipe[k][j-1];
        pipe[k][0] <= (mac_sload_v[k] ? 64'sd0 : pipe[k][0]) +
                      longint'($signed(mac_a_v[k])) * longint'($signed(mac_b_v[k]));
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rnd[k]          = (pipe[k][LAT-1] + 64'sd128) >>> 8;
      mac_res_v[k]    = rnd[k][15:0];
      mac_rvalid_v[k] = !force_err && (rnd[k] <= 64'sd32767) && (rnd[k] >= -64'sd32768);
    end
  end

  // Per-cycle trace of the handshake and MAC-side outputs of instance 0.
  int cyc = 0;
  bit          acc_at [NREC];
  logic [15:0] aa_at  [NREC];
  logic [15:0] ab_at  [NREC];
  bit          ce_at  [NREC];
  bit          sl_at  [NREC];
  bit          rv_at  [NREC];
  logic [15:0] ma_at  [NREC];
  logic [15:0] mb_at  [NREC];

  always @(posedge clk) begin
    if (cyc < NREC) begin
      acc_at[cyc] <= in_valid && in_ready_v[0];
      aa_at[cyc]  <= in_a;
      ab_at[cyc]  <= in_b;
      ce_at[cyc]  <= mac_ce_v[0];
      sl_at[cyc]  <= mac_sload_v[0];
      rv_at[cyc]  <= res_valid_v[0];
      ma_at[cyc]  <= mac_a_v[0];
      mb_at[cyc]  <= mac_b_v[0];
    end
    cyc <= cyc + 1;
  end

  logic [15:0] pa [$];
  logic [15:0] pb [$];
  int first_acc, last_acc, res_cyc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_calc(output logic [15:0] d, output logic e);
    longint s = 0;
    longint r;
    foreach (pa[i]) s += longint'($signed(pa[i])) * longint'($signed(pb[i]));
    r = (s + 64'sd128) >>> 8;
    d = r[15:0];
    e = force_err || (r > 64'sd32767) || (r < -64'sd32768);
  endfunction

  task automatic drive_pairs(input bit gaps);
    int to;
    first_acc = -1;
    for (int i = 0; i < pa.size(); i++) begin
      if (gaps && i > 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = pa[i];
      in_b     = pb[i];
      in_last  = (i == pa.size() - 1);
      to = 0;
      while (!in_ready_v[0] && to < 50) begin
        @(negedge clk);
        to++;
      end
      if (to >= 50) chk("in_ready_timeout", 0, 1);
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_result();
    int n = 0;
    while (!res_valid_v[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("res_valid_seen", res_valid_v[0], 1);
    res_cyc = cyc;
  endtask

  task automatic check_timeline();
    int errs = 0;
    int nfl  = 0;
    bit exp_ce;
    for (int c = first_acc + 1; c <= last_acc + LAT + 1 && c < NREC; c++) begin
      exp_ce = acc_at[c-1] || (c >= last_acc + 2);
      if (ce_at[c] != exp_ce) errs++;
      if (rv_at[c]) errs++;
      if (acc_at[c-1]) begin
        if (ma_at[c] !== aa_at[c-1] || mb_at[c] !== ab_at[c-1]) errs++;
        if (sl_at[c] != (c - 1 == first_acc)) errs++;
      end else if (c >= last_acc + 2) begin
        if (ce_at[c] && ma_at[c] == 16'h0 && mb_at[c] == 16'h0 && !sl_at[c]) nfl++;
      end
    end
    chk("ce_timeline_errs", errs, 0);
    chk("flush_cycles", nfl, LAT);
    chk("first_ce_sload", sl_at[first_acc + 1], 1);
    chk("res_latency", res_cyc - last_acc, LAT + 2);
    chk("ce_low_in_hold", mac_ce_v[0], 0);
  endtask

  task automatic release_res(input int hold, input bit junk);
    logic [15:0] d0 = res_data_v[0];
    logic        e0 = res_err_v[0];
    logic [7:0]  c0 = res_cnt0;
    int bad = 0;
    int accs = 0;
    int cs = cyc;
    repeat (hold) begin
      @(negedge clk);
      if (junk) begin
        in_valid = 1'b1;
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
      end
      if (in_ready_v[0] || !res_valid_v[0] || res_data_v[0] !== d0 ||
          res_err_v[0] !== e0 || res_cnt0 !== c0) bad++;
    end
    chk("hold_stable", bad, 0);
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    in_valid  = 1'b0;
    for (int c = cs; c < cyc && c < NREC; c++) if (acc_at[c]) accs++;
    chk("no_accept_in_hold", accs, 0);
    chk("valid_cleared", res_valid_v[0], 0);
    chk("ready_after_handshake", in_ready_v[0], 1);
  endtask

  task automatic run_dot(input bit gaps, input int hold, input bit junk, output logic [15:0] got);
    logic [15:0] ed;
    logic        ee;
    int          n = pa.size();
    ref_calc(ed, ee);
    drive_pairs(gaps);
    wait_result();
    check_timeline();
    chk("res_data", res_data_v[0], ed);
    chk("res_err", res_err_v[0], ee);
    chk("res_cnt_cw8", res_cnt0, (n > 255) ? 255 : n);
    chk("res_data_cw2", res_data_v[1], ed);
    chk("res_cnt_cw2", res_cnt1, (n > 3) ? 3 : n);
    chk("ready_low_in_hold", in_ready_v[0], 0);
    got = res_data_v[0];
    release_res(hold, junk);
  endtask

  function automatic logic any_out_set();
    return |{mac_ce_v, mac_sload_v, mac_a_v[0], mac_b_v[0], mac_a_v[1], mac_b_v[1],
             res_valid_v, res_data_v[0], res_data_v[1], res_err_v, res_cnt0, res_cnt1};
  endfunction

  initial begin
    logic [15:0] got, g0, g1;
    int n;
    arst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0;
    res_ready = 1'b0; force_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs_zero", any_out_set(), 0);
    arst_n = 1'b1;
    chk("ready_after_reset", in_ready_v[0], 1);

    pa = '{16'h0100, 16'h0080}; pb = '{16'h0200, 16'h0400};
    run_dot(0, 0, 0, got);
    chk("two_pair_result", got, 16'h0400);

    pa = '{16'h0300}; pb = '{16'h0100};
    run_dot(0, 1, 0, got);
    chk("single_pair_result", got, 16'h0300);

    pa = '{16'h0100, 16'h0080, 16'hFF00}; pb = '{16'h0200, 16'h0400, 16'h0180};
    run_dot(0, 0, 0, g0);
    run_dot(1, 2, 0, g1);
    chk("gap_result_same", g1, g0);

    force_err = 1'b1;
    pa = '{16'h0100}; pb = '{16'h0200};
    run_dot(0, 10, 1, got);
    force_err = 1'b0;

    pa = '{16'h0100, 16'h0100, 16'h0100}; pb = '{16'h0100, 16'h0100, 16'h0100};
    drive_pairs(0);
    @(negedge clk);
    arst_n = 1'b0;
    #1 chk("reset_in_flush_zero", any_out_set(), 0);
    @(negedge clk);
    chk("reset_held_zero", any_out_set(), 0);
    arst_n = 1'b1;
    chk("ready_after_reset2", in_ready_v[0], 1);
    n = 0;
    repeat (LAT + 6) begin
      @(negedge clk);
      if (res_valid_v != 2'b00) n++;
    end
    chk("no_valid_after_abort", n, 0);
    pa = '{16'h0100}; pb = '{16'h0100};
    run_dot(0, 0, 0, got);
    chk("post_reset_result", got, 16'h0100);

    pa.delete(); pb.delete();
    repeat (5) begin
      pa.push_back(16'h0100);
      pb.push_back(16'h0100);
    end
    run_dot(0, 0, 0, got);
    chk("five_pair_result", got, 16'h0500);
    chk("saturated_cnt_cw2", res_cnt1, 3);

    for (int t = 0; t < 8; t++) begin
      pa.delete(); pb.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        pa.push_back(16'($urandom_range(0, 16'h03FF)) - 16'h0200);
        pb.push_back(16'($urandom_range(0, 16'h03FF)) - 16'h0200);
      end
      run_dot(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/mac_seq.md
MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 Parameter N_LEN, default 16, operand and result width in bits.
REQ-002 Parameter Q_LEN, default 8, fractional bits; the block only passes Q_LEN through and does no arithmetic with it.
REQ-003 Parameter LAT, default 3, range 1..15: ce-qualified MAC cycles from the last operand pair to a valid result on mac_res.
REQ-004 Parameter CW, default 8, pair-counter width.
REQ-005 Clocking: one clock, clk; reset arst_n is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 arst_n  in  1  asynchronous active-low reset.
REQ-008 in_valid  in  1  an operand pair is offered.
REQ-009 in_ready  out  1  the block accepts a pair this cycle.
REQ-010 in_a, in_b  in  N_LEN each  signed operands.
REQ-011 in_last  in  1  the offered pair ends the current dot product.
REQ-012 mac_ce  out  1  clock enable to the MAC.
REQ-013 mac_sload  out  1  start of a new accumulation at the MAC.
REQ-014 mac_a, mac_b  out  N_LEN each  operands to the MAC.
REQ-015 mac_rvalid  in  1  MAC result is free of overflow/error.
REQ-016 mac_res  in  N_LEN  rounded MAC result.
REQ-017 res_valid  out  1  result available.
REQ-018 res_ready  in  1  the consumer accepts the result.
REQ-019 res_data  out  N_LEN  captured dot-product result.
REQ-020 res_err  out  1  captured inverse of mac_rvalid.
REQ-021 res_cnt  out  CW  number of pairs in the dot product, saturating at 2^CW-1.

Function
REQ-022 The FSM has exactly four states: IDLE, ACC, FLUSH, HOLD.
REQ-023 in_ready SHALL be 1 in IDLE and ACC and 0 in FLUSH and HOLD; a pair is accepted when in_valid and in_ready are both 1.
REQ-024 mac_ce, mac_sload, mac_a and mac_b SHALL be registered.
- Acceptance in cycle t: in_a/in_b appear on mac_a/mac_b and mac_ce=1 in cycle t+1.
- In any cycle with no acceptance and no flush: mac_ce=0 and mac_a/mac_b hold their values.
REQ-025 IDLE: acceptance registers mac_sload=1 and cnt=1, then moves to FLUSH if in_last=1, otherwise to ACC.
REQ-026 ACC: acceptance registers mac_sload=0 and cnt=cnt+1 (saturating), then moves to FLUSH if in_last=1; without acceptance it stays in ACC.
REQ-027 FLUSH: loads a down-counter with LAT on entry, then for LAT cycles drives mac_ce=1, mac_sload=0, mac_a=mac_b=0.
- The cycle after the last flush ce, the block captures mac_res into res_data and ~mac_rvalid into res_err, sets res_valid=1 and moves to HOLD.
REQ-028 HOLD: res_data, res_err and res_cnt SHALL stay stable while res_valid=1; res_valid&&res_ready clears res_valid and moves to IDLE.
REQ-029 IDLE also accepts a pair in the same cycle that the HOLD handshake returns to IDLE, but not earlier, so no pair is accepted while HOLD is active.
REQ-030 A single-pair dot product (in_last with the first pair) SHALL be legal: sload=1 and then flush.
REQ-031 At cnt=2^CW-1 the counter SHALL saturate without wrap-around, and res_cnt reports 2^CW-1.
REQ-032 Exactly one dot product SHALL be in flight at any time; mac_ce is never 1 in HOLD or IDLE except on an acceptance.

Reset
REQ-033 While arst_n=0, regardless of clk:
- state=IDLE;
- mac_ce=0, mac_sload=0, mac_a=0, mac_b=0;
- res_valid=0, res_data=0, res_err=0, res_cnt=0, cnt=0, flush counter=0.
REQ-034 Reset asserted mid-ACC or mid-FLUSH SHALL abandon the dot product with no res_valid pulse; the first pair after reset release carries mac_sload=1.
REQ-035 in_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-036 The bench SHALL use a behavioural MAC model with LAT=3 and Q8.8 format.
- Scenario: pairs (0x0100,0x0200) and (0x0080,0x0400, last) -> res_data=0x0400, res_err=0, res_cnt=2.
- Also checks: first mac_ce carries mac_sload=1; exactly 3 flush cycles with zero operands.
REQ-037 Single pair (0x0300,0x0100, last) -> res_data=0x0300, res_cnt=1, res_valid exactly LAT+2 cycles after acceptance.
REQ-038 Gaps in in_valid during ACC -> mac_ce=0 in gap cycles, result unchanged versus the gap-free run.
REQ-039 Model forces mac_rvalid=0 (overflow) -> res_err=1; res_ready held 0 for 10 cycles -> outputs stable, in_ready=0, then handshake returns to IDLE.
REQ-040 arst_n pulsed low during FLUSH -> no res_valid, all outputs 0.
- The next dot product (0x0100,0x0100, last) returns res_data=0x0100.
REQ-041 With CW=2, 5 pairs of (0x0100,0x0100) -> res_cnt=3 (saturated), res_data=0x0500.
